// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int   DEFAULT_DATA_BITS  = 8;
  localparam int   DEFAULT_OVERSAMPLE = 16;
  localparam logic LINE_IDLE          = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with async active-low reset.
module sync_2ff
  import uart_pkg::*;
#(
  parameter logic RESET_VAL = LINE_IDLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // two-stage chain resolving metastability on the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RESET_VAL;
      q_r    <= RESET_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/uart_rx_core.sv
// UART receive deserializer driven by an oversampling baud tick; samples mid-bit, LSB first.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TICK_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE   = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  uart_state_e            state_r, state_nxt;
  logic [TW-1:0]          tick_cnt_r, tick_cnt_nxt;
  logic [BW-1:0]          bit_cnt_r, bit_cnt_nxt;
  logic [DATA_BITS-1:0]   shift_r, shift_nxt;
  logic [DATA_BITS-1:0]   rx_data_r, rx_data_nxt;
  logic                   rx_valid_r, rx_valid_nxt;
  logic                   frame_err_r, frame_err_nxt;
  logic                   busy_r;
  logic                   rx_sync_s;

  sync_2ff #(
    .RESET_VAL (LINE_IDLE)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (rx),
    .q     (rx_sync_s)
  );

  // state, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      tick_cnt_r  <= TICK_ZERO;
      bit_cnt_r   <= BIT_ZERO;
      shift_r     <= {DATA_BITS{1'b0}};
      rx_data_r   <= {DATA_BITS{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      tick_cnt_r  <= tick_cnt_nxt;
      bit_cnt_r   <= bit_cnt_nxt;
      shift_r     <= shift_nxt;
      rx_data_r   <= rx_data_nxt;
      rx_valid_r  <= rx_valid_nxt;
      frame_err_r <= frame_err_nxt;
      busy_r      <= (state_nxt != IDLE);
    end
  end

  // next-state logic; everything holds unless a baud tick is present
  always_comb begin
    state_nxt     = state_r;
    tick_cnt_nxt  = tick_cnt_r;
    bit_cnt_nxt   = bit_cnt_r;
    shift_nxt     = shift_r;
    rx_data_nxt   = rx_data_r;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    if (baud_tick) begin
      case (state_r)
        IDLE: begin
          if (rx_sync_s == 1'b0) begin
            state_nxt    = START;
            tick_cnt_nxt = TICK_ZERO;
          end else begin
            state_nxt = IDLE;
          end
        end
        START: begin
          if (tick_cnt_r == TICK_MID) begin
            tick_cnt_nxt = TICK_ZERO;
            if (rx_sync_s == 1'b0) begin
              state_nxt   = DATA;
              bit_cnt_nxt = BIT_ZERO;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            tick_cnt_nxt = tick_cnt_r + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_cnt_r == TICK_LAST) begin
            shift_nxt    = {rx_sync_s, shift_r[DATA_BITS-1:1]};
            tick_cnt_nxt = TICK_ZERO;
            bit_cnt_nxt  = bit_cnt_r + BIT_ONE;
            if (bit_cnt_r == BIT_LAST) begin
              state_nxt = STOP;
            end else begin
              state_nxt = DATA;
            end
          end else begin
            tick_cnt_nxt = tick_cnt_r + TICK_ONE;
          end
        end
        STOP: begin
          // sampling mid stop bit re-arms IDLE half a bit early for back-to-back frames
          if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_nxt = TICK_ZERO;
            state_nxt    = IDLE;
            if (rx_sync_s == 1'b1) begin
              rx_data_nxt  = shift_r;
              rx_valid_nxt = 1'b1;
            end else begin
              frame_err_nxt = 1'b1;
            end
          end else begin
            tick_cnt_nxt = tick_cnt_r + TICK_ONE;
          end
        end
        default: begin
          state_nxt    = IDLE;
          tick_cnt_nxt = TICK_ZERO;
          bit_cnt_nxt  = BIT_ZERO;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receive deserializer. Sits directly downstream of the rx baud tick generator and consumes its single-cycle `baud_tick` strobe.
- The generator instance feeding this block is configured with BAUD_RATE × OVERSAMPLE, so one tick equals 1/OVERSAMPLE of a bit period.
- Synchronizes the `rx` line, detects and qualifies the start bit, and samples data mid-bit, LSB first. Presents each byte with a one-cycle valid strobe, or flags a framing error.

Parameters:
- DATA_BITS, 8, data bits per frame (5–8 legal).
- OVERSAMPLE, 16, baud ticks per bit period (even, ≥4).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- baud_tick  in  1  one-clk strobe, OVERSAMPLE per bit, from the rx baud generator.
- rx  in  1  asynchronous serial line; idles high.
- rx_data  out  DATA_BITS  last correctly framed byte.
- rx_valid  out  1  one-clk pulse: rx_data updated.
- frame_err  out  1  one-clk pulse: stop bit sampled low.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; tick_cnt=0; bit_cnt=0; shift reg=0; rx_data=0; rx_valid=0; frame_err=0; busy=0; synchronizer flops=1.
- rx passes through a 2-FF synchronizer (rx_s). All decisions use rx_s and are taken only on clk edges where baud_tick=1. With baud_tick=0, all state and counters hold.
- IDLE: on a tick with rx_s=0 → START, tick_cnt=0.
- START:
  - Each tick increments tick_cnt.
  - On the tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit): if rx_s=0 → DATA, tick_cnt=0, bit_cnt=0.
  - Otherwise it is a false start → IDLE, with no output pulse.
- DATA:
  - Each tick increments tick_cnt.
  - At tick_cnt==OVERSAMPLE-1: sample rx_s into the shift register MSB and shift right (LSB first), tick_cnt=0, bit_cnt++.
  - When bit_cnt reaches DATA_BITS → STOP.
- STOP:
  - At tick_cnt==OVERSAMPLE-1: sample rx_s.
  - If 1: rx_data ← shift reg; rx_valid=1 for one clk.
  - If 0: frame_err=1 for one clk; rx_data unchanged.
  - Either case → IDLE.
- Latency: the rx_valid/frame_err pulse appears on the clk edge where the stop-bit sample occurs. The pulse is registered and visible the following cycle; it clears on the next clk regardless of baud_tick.
- Stop-sample timing: the stop sample lands mid stop bit, so the return to IDLE happens a half bit early. This lets a back-to-back start bit be caught with no dead time.
- rx_valid and frame_err are never high together.
- Frame length: from the start-detect tick, a frame is OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks until the result. This is 152 ticks at the defaults.
- A break (rx held low) produces one frame_err with data 0x00. The block then re-arms in IDLE and sees the low line as a new start each frame; the break persists as repeated frame_err pulses.
- Async reset mid-frame aborts immediately with no pulse. After reset deassertion the block waits in IDLE for a fresh falling level.
- Counter widths: tick_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS+1) bits. No wrap occurs beyond the compared maxima.

Decomposition:
- Shared package `uart_pkg`:
  - state enum IDLE/START/DATA/STOP (2-bit encoding).
  - Defaults DATA_BITS=8, OVERSAMPLE=16.
  - Idle line level constant 1'b1.
- One natural sub-module: `sync_2ff`, a generic 1-bit two-flop synchronizer with async active-low reset and parameterized reset value (here 1).

Test Plan:
- Byte reception: baud_tick held high every clk, OVERSAMPLE=16; drive 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 clk/bit → rx_data=0xA5, a single one-clk rx_valid, frame_err never high, busy low afterwards.
- Glitch rejection: rx low for 4 ticks then high → no rx_valid, no frame_err; busy returns low within 8 ticks.
- Framing error: frame carrying 0x3C with stop bit low → one frame_err pulse, rx_data keeps its previous value 0xA5, rx_valid stays 0.
- Back-to-back frames: 0x00 then 0xFF with zero idle between → two rx_valid pulses 160 ticks apart, values 0x00 then 0xFF.
- Reset mid-frame: assert rst low during bit 3 of 0x55 → outputs and busy go 0 asynchronously; after release, a clean 0x81 frame is received correctly.
- Sparse ticks: baud_tick every 5th clk → 0xC3 still received. rx_valid is exactly one clk wide, and state holds between ticks.
